// File: rtl/cp0_irq_timer.sv
// ---------------------------------------------------------------------------
// cp0_irq_timer
//
// CP0 register file for the EX/MEM exception stage. Holds the exception/eret
// register set (Status, Cause, EPC, ErrEPC, BadVAddr), a Wired-bounded Random
// register for tlbwr, read-only Config1, sampled hardware interrupt lines and
// the masked interrupt request fed back to the pipeline. The Count/Compare
// timer and its timer interrupt (Cause.TI) are built only when the macro
// CP0_TIMER_EN is defined; otherwise Count/Compare read 0 and TI is 0.
//
// Parameters
//   TLB_ENTRY_NUM  TLB entries (2..64): Random upper bound, Config1.MMUSize
//   HW_INT_NUM     external interrupt lines (1..6) -> Cause.IP[2+N-1:2]
//   COUNT_DIV      enabled cycles per Count increment (1..16)
//   STATUS_RESET   Status reset value (writable bits only are kept)
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   cp0_enable                    global state-update enable
//   read_reg_num/sel, read_data   mfc0 port (combinational, no bypass)
//   write_enable, write_reg_num/sel, write_data   mtc0 port
//   hw_int                        external interrupt levels (sampled)
//   is_exception, Cause_ExcCode_from_exception, EPC_from_exception,
//   in_delayslot, BadVAddr_write_enable, BadVAddr_from_exception
//                                 exception commit
//   eret                          eret commit
//   int_req                       pending enabled interrupt
//   out_Status, out_Cause, out_EPC, eret_pc, out_Random   direct views
// ---------------------------------------------------------------------------
module cp0_irq_timer #(
    parameter int          TLB_ENTRY_NUM = 16,
    parameter int          HW_INT_NUM    = 6,
    parameter int          COUNT_DIV     = 2,
    parameter logic [31:0] STATUS_RESET  = 32'h0040_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cp0_enable,
    input  logic [4:0]            read_reg_num,
    input  logic [2:0]            read_reg_sel,
    output logic [31:0]           read_data,
    input  logic                  write_enable,
    input  logic [4:0]            write_reg_num,
    input  logic [2:0]            write_reg_sel,
    input  logic [31:0]           write_data,
    input  logic [HW_INT_NUM-1:0] hw_int,
    input  logic                  is_exception,
    input  logic [4:0]            Cause_ExcCode_from_exception,
    input  logic [31:0]           EPC_from_exception,
    input  logic                  in_delayslot,
    input  logic                  BadVAddr_write_enable,
    input  logic [31:0]           BadVAddr_from_exception,
    input  logic                  eret,
    output logic                  int_req,
    output logic [31:0]           out_Status,
    output logic [31:0]           out_Cause,
    output logic [31:0]           out_EPC,
    output logic [31:0]           eret_pc,
    output logic [5:0]            out_Random
);

    // Parameter range checks, resolved at elaboration.
    if (TLB_ENTRY_NUM < 2 || TLB_ENTRY_NUM > 64) begin : g_bad_tlb
        $error("cp0_irq_timer: TLB_ENTRY_NUM out of range 2..64");
    end
    if (HW_INT_NUM < 1 || HW_INT_NUM > 6) begin : g_bad_hw_int
        $error("cp0_irq_timer: HW_INT_NUM out of range 1..6");
    end
    if (COUNT_DIV < 1 || COUNT_DIV > 16) begin : g_bad_div
        $error("cp0_irq_timer: COUNT_DIV out of range 1..16");
    end

    localparam logic [5:0]  RANDOM_MAX    = 6'(TLB_ENTRY_NUM - 1);
    localparam logic [31:0] STATUS_MASK   = 32'h0040_FF07;   // BEV, IM, ERL, EXL, IE
    localparam logic [31:0] CONFIG1_VALUE = {1'b0, RANDOM_MAX, 25'd0};

    // {num, sel} keys of the implemented registers.
    localparam logic [7:0] REG_RANDOM   = {5'd1,  3'd0};
    localparam logic [7:0] REG_WIRED    = {5'd6,  3'd0};
    localparam logic [7:0] REG_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] REG_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] REG_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] REG_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] REG_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] REG_EPC      = {5'd14, 3'd0};
    localparam logic [7:0] REG_CONFIG1  = {5'd16, 3'd1};
    localparam logic [7:0] REG_ERREPC   = {5'd30, 3'd0};

    // Status bit positions.
    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int ST_ERL = 2;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [5:0]            random_q,   random_d;
    logic [5:0]            wired_q,    wired_d;
    logic [31:0]           badvaddr_q, badvaddr_d;
    logic [31:0]           status_q,   status_d;
    logic                  bd_q,       bd_d;
    logic                  iv_q,       iv_d;
    logic [1:0]            ip_sw_q,    ip_sw_d;
    logic [4:0]            exccode_q,  exccode_d;
    logic [HW_INT_NUM-1:0] hw_int_q;
    logic [31:0]           epc_q,      epc_d;
    logic [31:0]           errepc_q,   errepc_d;
    logic                  ti;

    // -----------------------------------------------------------------------
    // mtc0 decode
    // -----------------------------------------------------------------------
    logic [7:0] wr_key;
    logic       wr_wired, wr_status, wr_cause, wr_epc, wr_errepc;

    assign wr_key    = {write_reg_num, write_reg_sel};
    assign wr_wired  = write_enable && (wr_key == REG_WIRED);
    assign wr_status = write_enable && (wr_key == REG_STATUS);
    assign wr_cause  = write_enable && (wr_key == REG_CAUSE);
    assign wr_epc    = write_enable && (wr_key == REG_EPC);
    assign wr_errepc = write_enable && (wr_key == REG_ERREPC);

`ifdef CP0_TIMER_EN
    // -----------------------------------------------------------------------
    // Count/Compare timer
    // -----------------------------------------------------------------------
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic             wr_count, wr_compare;
    logic [DIV_W-1:0] div_q,     div_d;
    logic [31:0]      count_q,   count_d;
    logic [31:0]      compare_q, compare_d;
    logic             ti_q,      ti_d;
    logic             tick;
    logic [31:0]      count_inc;

    assign wr_count   = write_enable && (wr_key == REG_COUNT);
    assign wr_compare = write_enable && (wr_key == REG_COMPARE);
    assign tick       = (div_q == DIV_W'(COUNT_DIV - 1));
    assign count_inc  = count_q + 32'd1;

    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path through the block leaves it unassigned and infers a latch.
    always_comb begin
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        count_d   = tick ? count_inc : count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        // TI is sticky until the next Compare write.
        if (tick && !wr_count && (count_inc == compare_q)) begin
            ti_d = 1'b1;
        end
        if (wr_count) begin
            count_d = write_data;
            div_d   = '0;
        end
        // A Compare write beats a same-cycle match.
        if (wr_compare) begin
            compare_d = write_data;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else if (cp0_enable) begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign ti = ti_q;
`else
    assign ti = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic: exception > eret > mtc0 where they touch one field
    // -----------------------------------------------------------------------
    always_comb begin
        // Random: tlbwr victim pointer in [Wired, TLB_ENTRY_NUM-1].
        if (wr_wired || (random_q <= wired_q)) begin
            random_d = RANDOM_MAX;
        end else begin
            random_d = random_q - 6'd1;
        end

        wired_d = wired_q;
        if (wr_wired) begin
            wired_d = (write_data[5:0] > RANDOM_MAX) ? RANDOM_MAX : write_data[5:0];
        end

        // BadVAddr is architecturally read-only; only exceptions load it.
        badvaddr_d = badvaddr_q;
        if (is_exception && BadVAddr_write_enable) begin
            badvaddr_d = BadVAddr_from_exception;
        end

        status_d = status_q;
        if (wr_status) begin
            status_d = write_data & STATUS_MASK;
        end
        if (is_exception) begin
            status_d[ST_EXL] = 1'b1;
        end else if (eret) begin
            if (status_q[ST_ERL]) begin
                status_d[ST_ERL] = 1'b0;
            end else begin
                status_d[ST_EXL] = 1'b0;
            end
        end

        iv_d    = wr_cause ? write_data[23]  : iv_q;
        ip_sw_d = wr_cause ? write_data[9:8] : ip_sw_q;

        // A nested exception (EXL already set) keeps the original EPC/BD so
        // the outer handler still returns to the first faulting PC.
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = wr_epc ? write_data : epc_q;
        if (is_exception) begin
            exccode_d = Cause_ExcCode_from_exception;
            epc_d     = epc_q;
            if (!status_q[ST_EXL]) begin
                epc_d = EPC_from_exception;
                bd_d  = in_delayslot;
            end
        end

        errepc_d = errepc_q;
        if (is_exception) begin
            errepc_d = EPC_from_exception;
        end else if (wr_errepc) begin
            errepc_d = write_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    // NOTE: every register here is small control state and gets an explicit
    // reset value; nothing in this block is a memory array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            random_q   <= RANDOM_MAX;
            wired_q    <= '0;
            badvaddr_q <= '0;
            status_q   <= STATUS_RESET & STATUS_MASK;
            bd_q       <= 1'b0;
            iv_q       <= 1'b0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
            hw_int_q   <= '0;
            epc_q      <= '0;
            errepc_q   <= '0;
        end else if (cp0_enable) begin
            random_q   <= random_d;
            wired_q    <= wired_d;
            badvaddr_q <= badvaddr_d;
            status_q   <= status_d;
            bd_q       <= bd_d;
            iv_q       <= iv_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            hw_int_q   <= hw_int;
            epc_q      <= epc_d;
            errepc_q   <= errepc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Cause view and interrupt request
    // -----------------------------------------------------------------------
    logic [5:0]  hw_ip;
    logic [7:0]  cause_ip;
    logic [31:0] cause_value;

    always_comb begin
        hw_ip                   = '0;
        hw_ip[HW_INT_NUM-1:0]   = hw_int_q;
        // IP7 is shared between hw line 5 and the timer interrupt.
        cause_ip    = {hw_ip[5] | ti, hw_ip[4:0], ip_sw_q};
        cause_value = {bd_q, ti, 6'd0, iv_q, 7'd0, cause_ip, 1'b0, exccode_q, 2'b00};
    end

    assign int_req = status_q[ST_IE] & ~status_q[ST_EXL] & ~status_q[ST_ERL]
                   & (|(cause_ip & status_q[15:8]));

    assign out_Status = status_q;
    assign out_Cause  = cause_value;
    assign out_EPC    = epc_q;
    assign eret_pc    = status_q[ST_ERL] ? errepc_q : epc_q;
    assign out_Random = random_q;

    // -----------------------------------------------------------------------
    // mfc0 read mux
    // -----------------------------------------------------------------------
    always_comb begin
        read_data = '0;
        case ({read_reg_num, read_reg_sel})
            REG_RANDOM:   read_data = {26'd0, random_q};
            REG_WIRED:    read_data = {26'd0, wired_q};
            REG_BADVADDR: read_data = badvaddr_q;
`ifdef CP0_TIMER_EN
            REG_COUNT:    read_data = count_q;
            REG_COMPARE:  read_data = compare_q;
`endif
            REG_STATUS:   read_data = status_q;
            REG_CAUSE:    read_data = cause_value;
            REG_EPC:      read_data = epc_q;
            REG_CONFIG1:  read_data = CONFIG1_VALUE;
            REG_ERREPC:   read_data = errepc_q;
            default:      read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_irq_timer.sv
module tb_cp0_irq_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cp0_enable;
    logic [4:0]  read_reg_num;
    logic [2:0]  read_reg_sel;
    logic [31:0] read_data;
    logic        write_enable;
    logic [4:0]  write_reg_num;
    logic [2:0]  write_reg_sel;
    logic [31:0] write_data;
    logic [5:0]  hw_int;
    logic        is_exception;
    logic [4:0]  Cause_ExcCode_from_exception;
    logic [31:0] EPC_from_exception;
    logic        in_delayslot;
    logic        BadVAddr_write_enable;
    logic [31:0] BadVAddr_from_exception;
    logic        eret;
    logic        int_req;
    logic [31:0] out_Status;
    logic [31:0] out_Cause;
    logic [31:0] out_EPC;
    logic [31:0] eret_pc;
    logic [5:0]  out_Random;

    int vectors    = 0;
    int miscompares = 0;

    cp0_irq_timer #(
        .TLB_ENTRY_NUM(16),
        .HW_INT_NUM   (6),
        .COUNT_DIV    (2),
        .STATUS_RESET (32'h0040_0001)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .cp0_enable                   (cp0_enable),
        .read_reg_num                 (read_reg_num),
        .read_reg_sel                 (read_reg_sel),
        .read_data                    (read_data),
        .write_enable                 (write_enable),
        .write_reg_num                (write_reg_num),
        .write_reg_sel                (write_reg_sel),
        .write_data                   (write_data),
        .hw_int                       (hw_int),
        .is_exception                 (is_exception),
        .Cause_ExcCode_from_exception (Cause_ExcCode_from_exception),
        .EPC_from_exception           (EPC_from_exception),
        .in_delayslot                 (in_delayslot),
        .BadVAddr_write_enable        (BadVAddr_write_enable),
        .BadVAddr_from_exception      (BadVAddr_from_exception),
        .eret                         (eret),
        .int_req                      (int_req),
        .out_Status                   (out_Status),
        .out_Cause                    (out_Cause),
        .out_EPC                      (out_EPC),
        .eret_pc                      (eret_pc),
        .out_Random                   (out_Random)
    );

    always #5 clk = ~clk;

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; return 1 ns after the last edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mtc0(input logic [4:0] num, input logic [2:0] sel, input logic [31:0] data);
        write_enable  = 1'b1;
        write_reg_num = num;
        write_reg_sel = sel;
        write_data    = data;
        step();
        write_enable  = 1'b0;
    endtask

    task automatic rd(input logic [4:0] num, input logic [2:0] sel);
        read_reg_num = num;
        read_reg_sel = sel;
        #1;
    endtask

    task automatic take_exc(input logic [4:0] code, input logic [31:0] epc, input logic ds,
                            input logic bva_we, input logic [31:0] bva);
        is_exception                 = 1'b1;
        Cause_ExcCode_from_exception = code;
        EPC_from_exception           = epc;
        in_delayslot                 = ds;
        BadVAddr_write_enable        = bva_we;
        BadVAddr_from_exception      = bva;
        step();
        is_exception          = 1'b0;
        BadVAddr_write_enable = 1'b0;
        in_delayslot          = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        cp0_enable = 1'b1;
        read_reg_num = '0;
        read_reg_sel = '0;
        write_enable = 1'b0;
        write_reg_num = '0;
        write_reg_sel = '0;
        write_data = '0;
        hw_int = '0;
        is_exception = 1'b0;
        Cause_ExcCode_from_exception = '0;
        EPC_from_exception = '0;
        in_delayslot = 1'b0;
        BadVAddr_write_enable = 1'b0;
        BadVAddr_from_exception = '0;
        eret = 1'b0;

        // ---- reset state ----
        step(2);
        check("rst_random", out_Random, 32'd15);
        check("rst_status", out_Status, 32'h0040_0001);
        check("rst_int_req", int_req, 32'd0);
        rst = 1'b1;
        check("rst_cause", out_Cause, 32'h0);
        check("rst_epc", out_EPC, 32'h0);
        rd(16, 1); check("config1", read_data, 32'h1E00_0000);
        rd(6, 0);  check("rst_wired", read_data, 32'd0);
        rd(9, 0);  check("rst_count", read_data, 32'd0);

        // ---- Wired / Random ----
        mtc0(6, 0, 32'd10);
        check("random_after_wired", out_Random, 32'd15);
        rd(6, 0); check("wired10", read_data, 32'd10);
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("random_dec%0d", i), out_Random, 32'(15 - i));
        end
        step(); check("random_wrap", out_Random, 32'd15);
        step(); check("random_14", out_Random, 32'd14);
        cp0_enable = 1'b0;
        step(3); check("random_hold_disabled", out_Random, 32'd14);
        cp0_enable = 1'b1;
        step(); check("random_resume", out_Random, 32'd13);
        mtc0(6, 0, 32'd20);
        rd(6, 0); check("wired_saturate", read_data, 32'd15);
        check("random_after_wired20", out_Random, 32'd15);
        step(); check("random_pinned", out_Random, 32'd15);
        rd(1, 0); check("random_read", read_data, 32'd15);
        mtc0(6, 0, 32'd0);

        // ---- read-only / unimplemented / write masks ----
        mtc0(2, 0, 32'hDEAD_BEEF);
        rd(2, 0); check("unimpl_read", read_data, 32'h0);
        mtc0(16, 1, 32'h0);
        rd(16, 1); check("config1_ro", read_data, 32'h1E00_0000);
        mtc0(12, 0, 32'hFFFF_FFFF);
        check("status_mask", out_Status, 32'h0040_FF07);

        // ---- hardware interrupt sampling ----
        mtc0(12, 0, 32'h0040_0801);
        hw_int = 6'b000010;
        #1;
        check("ip3_not_yet", out_Cause, 32'h0);
        check("int_req_not_yet", int_req, 32'd0);
        step();
        check("ip3_sampled", out_Cause, 32'h0000_0800);
        check("int_req_hw", int_req, 32'd1);
        mtc0(12, 0, 32'h0040_0803);
        check("int_req_exl_mask", int_req, 32'd0);
        hw_int = 6'b000000;
        mtc0(12, 0, 32'h0040_0801);
        check("ip3_cleared", out_Cause, 32'h0);
        check("int_req_cleared", int_req, 32'd0);

        // ---- nested exception ----
        take_exc(5'd4, 32'hBFC0_0100, 1'b1, 1'b1, 32'h1234_5678);
        check("exc1_epc", out_EPC, 32'hBFC0_0100);
        check("exc1_cause", out_Cause, 32'h8000_0010);
        check("exc1_status", out_Status, 32'h0040_0803);
        rd(30, 0); check("exc1_errepc", read_data, 32'hBFC0_0100);
        rd(8, 0);  check("exc1_badvaddr", read_data, 32'h1234_5678);
        take_exc(5'd8, 32'hBFC0_0200, 1'b0, 1'b0, 32'hFFFF_FFFF);
        check("exc2_epc_held", out_EPC, 32'hBFC0_0100);
        check("exc2_cause", out_Cause, 32'h8000_0020);
        rd(30, 0); check("exc2_errepc", read_data, 32'hBFC0_0200);
        rd(8, 0);  check("exc2_badvaddr_held", read_data, 32'h1234_5678);

        // ---- eret with ERL and EXL set ----
        mtc0(12, 0, 32'h0040_0807);
        check("eret_pc_errepc", eret_pc, 32'hBFC0_0200);
        eret = 1'b1; step(); eret = 1'b0;
        check("eret1_status", out_Status, 32'h0040_0803);
        check("eret_pc_epc", eret_pc, 32'hBFC0_0100);
        eret = 1'b1; step(); eret = 1'b0;
        check("eret2_status", out_Status, 32'h0040_0801);

        // ---- exception beats a same-cycle Status write ----
        write_enable  = 1'b1;
        write_reg_num = 5'd12;
        write_reg_sel = 3'd0;
        write_data    = 32'h0040_0801;
        take_exc(5'h0A, 32'h8000_0400, 1'b0, 1'b0, 32'h0);
        write_enable  = 1'b0;
        check("prio_status", out_Status, 32'h0040_0803);
        check("prio_epc", out_EPC, 32'h8000_0400);
        check("prio_cause", out_Cause, 32'h0000_0028);
        eret = 1'b1; step(); eret = 1'b0;

        // ---- Cause software bits ----
        mtc0(13, 0, 32'hFFFF_FFFF);
        check("cause_sw_write", out_Cause, 32'h0080_0328);
        check("sw_int_masked", int_req, 32'd0);
        mtc0(12, 0, 32'h0040_0101);
        check("sw_int_req", int_req, 32'd1);
        mtc0(13, 0, 32'h0);
        check("cause_sw_clear", out_Cause, 32'h0000_0028);
        check("sw_int_clear", int_req, 32'd0);

`ifdef CP0_TIMER_EN
        // ---- Count/Compare timer ----
        mtc0(12, 0, 32'h0040_8001);
        mtc0(11, 0, 32'd5);
        mtc0(9, 0, 32'd0);
        step(9);
        check("timer_9_cause", out_Cause, 32'h0000_0028);
        check("timer_9_int", int_req, 32'd0);
        rd(9, 0); check("timer_9_count", read_data, 32'd4);
        step();
        check("timer_10_cause", out_Cause, 32'h4000_8028);
        check("timer_10_int", int_req, 32'd1);
        rd(9, 0); check("timer_10_count", read_data, 32'd5);
        mtc0(11, 0, 32'd100);
        check("compare_clr_cause", out_Cause, 32'h0000_0028);
        check("compare_clr_int", int_req, 32'd0);
        rd(11, 0); check("compare_read", read_data, 32'd100);
`else
        mtc0(11, 0, 32'd5);
        mtc0(9, 0, 32'd7);
        rd(9, 0);  check("count_absent", read_data, 32'd0);
        rd(11, 0); check("compare_absent", read_data, 32'd0);
`endif

        // ---- asynchronous reset mid-count ----
        mtc0(6, 0, 32'd0);
        mtc0(12, 0, 32'h0040_0101);
        mtc0(13, 0, 32'h0000_0100);
        check("pre_reset_int", int_req, 32'd1);
        mtc0(9, 0, 32'd37);
`ifdef CP0_TIMER_EN
        rd(9, 0); check("count37", read_data, 32'd37);
`endif
        step(2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_random", out_Random, 32'd15);
        check("arst_status", out_Status, 32'h0040_0001);
        check("arst_int_req", int_req, 32'd0);
        check("arst_cause", out_Cause, 32'h0);
        rd(9, 0); check("arst_count", read_data, 32'd0);
        step();
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cp0_irq_timer.md
Name: cp0_irq_timer

Overview:
- Parametrised successor to the current CP0 register file.
- Keeps the exception/eret register set and adds:
  - Count/Compare timer with timer interrupt
  - Sampled hardware interrupt lines
  - Masked interrupt request generation
  - Wired-bounded auto-decrementing Random
  - TLB size set by parameter
- Sits beside the EX/MEM exception stage. Pipeline reads/writes via mtc0/mfc0 and takes `int_req` as an interrupt exception source.

Parameters:
- TLB_ENTRY_NUM, 16, TLB entries; sets Random upper bound and Config1.MMUSize (2..64).
- HW_INT_NUM, 6, external interrupt lines mapped to Cause.IP[2+HW_INT_NUM-1:2] (1..6).
- COUNT_DIV, 2, Count increments once every COUNT_DIV enabled cycles (1..16).
- STATUS_RESET, 32'h0040_0001, Status reset value (BEV=1, IE=1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cp0_enable  in  1  state update enable; when low, all registers hold (timer and Random included)
- read_reg_num  in  5  mfc0 register number
- read_reg_sel  in  3  mfc0 select
- read_data  out  32  combinational read data
- write_enable  in  1  mtc0 strobe
- write_reg_num  in  5  mtc0 register number
- write_reg_sel  in  3  mtc0 select
- write_data  in  32  mtc0 data
- hw_int  in  HW_INT_NUM  external interrupt levels, asynchronous to instruction flow
- is_exception  in  1  exception commit this cycle
- Cause_ExcCode_from_exception  in  5  ExcCode
- EPC_from_exception  in  32  faulting/restart PC
- in_delayslot  in  1  faulting instruction in delay slot
- BadVAddr_write_enable  in  1  update BadVAddr on exception
- BadVAddr_from_exception  in  32  bad address
- eret  in  1  eret commit
- int_req  out  1  pending enabled interrupt
- out_Status  out  32  Status
- out_Cause  out  32  Cause
- out_EPC  out  32  EPC
- eret_pc  out  32  ErrEPC if Status.ERL else EPC
- out_Random  out  6  Random[5:0] for tlbwr

Behaviour:
- Implemented registers {num,sel}: Random{1,0}, Wired{6,0}, BadVAddr{8,0}, Count{9,0}, Compare{11,0}, Status{12,0}, Cause{13,0}, EPC{14,0}, Config1{16,1}, ErrEPC{30,0}. All others read 0; writes to them are ignored.
- Reset (async, rst=0):
  - Random=TLB_ENTRY_NUM-1
  - Status=STATUS_RESET
  - Config1[30:25]=TLB_ENTRY_NUM-1, rest 0
  - All other registers, the divider and the hw_int sample register = 0
  - int_req=0
- Status:
  - Writable bits: BEV[22], IM[15:8], ERL[2], EXL[1], IE[0]. All other bits read 0.
- Cause:
  - BD[31], TI[30], IV[23], IP[15:8], ExcCode[6:2]. All other bits read 0.
  - Software-writable: IV, IP[9:8] only.
  - IP[7:2] = registered hw_int (1-cycle sample delay); unmapped lines read 0.
  - IP[7] is additionally ORed with TI.
- Timer:
  - Divider counts 0..COUNT_DIV-1. Count += 1 on wrap (32-bit, wraps at 2^32).
  - TI sets when the post-increment Count equals Compare.
  - Compare write clears TI.
  - Count write loads the value and clears the divider.
  - Same-cycle increment-match and Compare write: the write wins (TI=0).
- Random:
  - Decrements every enabled cycle.
  - At value Wired (or below, after a Wired write), loads TLB_ENTRY_NUM-1.
  - Wired write (5:0 kept, max TLB_ENTRY_NUM-1, larger values saturate) resets Random to TLB_ENTRY_NUM-1.
  - Random is read-only.
- int_req = Status.IE & ~Status.EXL & ~Status.ERL & |(Cause.IP & Status.IM). Combinational from registers.
- is_exception:
  - ExcCode written; EXL=1.
  - If EXL was 0: EPC=EPC_from_exception and BD=in_delayslot. Otherwise EPC and BD hold.
  - ErrEPC=EPC_from_exception.
  - BadVAddr updated when BadVAddr_write_enable=1.
- eret: if ERL clears ERL, else clears EXL.
- Same-cycle priority: is_exception > eret > mtc0 on the same field. A mtc0 to Status coinciding with is_exception keeps EXL=1.
- read_data returns current register values. No write-to-read bypass; the pipeline forwards.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined: timer as above.
- Undefined: Count and Compare read 0, writes ignored, TI constant 0, no divider logic; IP[7] = hw_int[5] only.

Test Plan:
- Reset mid-count: Count=37, assert rst asynchronously -> Count=0, Random=15, Status=32'h0040_0001, int_req=0 before the next clk edge.
- COUNT_DIV=2, Compare=5, Count=0, IM7=1, IE=1 -> TI=1 and int_req=1 after exactly 10 enabled cycles. Compare rewrite -> TI=0 next cycle.
- Wired=10, TLB_ENTRY_NUM=16 -> Random sequence 15,14,...,10,15. Wired=20 -> Wired reads 15.
- hw_int[1]=1, IM3=1, IE=1, EXL=0 -> Cause.IP3=1 one cycle later and int_req=1. Set EXL -> int_req=0.
- Nested exception: first EPC=0xBFC0_0100 with in_delayslot=1, second EPC=0xBFC0_0200 while EXL=1 -> EPC=0xBFC0_0100, BD=1, ErrEPC=0xBFC0_0200.
- eret with ERL=1, EXL=1 -> ERL=0, EXL stays 1, eret_pc switches from ErrEPC to EPC.
